// File: rtl/text_pkg.sv
// Shared types and constants for the UART text buffer.
// UART_TEXT_SCROLL_EN adds the scroll states to the state enum.
package text_pkg;

  localparam int COLS_DEFAULT = 16;
  localparam int ROWS_DEFAULT = 4;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE
`ifdef UART_TEXT_SCROLL_EN
    ,
    ST_SCR_RD,
    ST_SCR_WR,
    ST_SCR_BLANK
`endif
  } state_t;

endpackage

// File: rtl/char_ram.sv
// Character cell memory: one synchronous write port, an async renderer read port
// and, when UART_TEXT_SCROLL_EN is defined, an async read port for the scroll engine.
module char_ram #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
`ifdef UART_TEXT_SCROLL_EN
  ,
  input  logic [ADDR_W-1:0] scr_addr,
  output logic [7:0]        scr_data
`endif
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rd_data = mem[rd_addr];

`ifdef UART_TEXT_SCROLL_EN
  assign scr_data = mem[scr_addr];
`endif

endmodule

// File: rtl/uart_text_buffer.sv
// Terminal-style character store fed by the UART receiver, read by the text renderer.
// Define UART_TEXT_SCROLL_EN to scroll up on a last-row newline instead of wrapping.
module uart_text_buffer
  import text_pkg::*;
#(
  parameter int         COLS       = COLS_DEFAULT,
  parameter int         ROWS       = ROWS_DEFAULT,
  parameter logic [7:0] BLANK_CHAR = 8'h20,
  localparam int        ADDR_W     = $clog2(COLS * ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] charAddress,
  output logic [7:0]        charOutput,
  output logic [ADDR_W-1:0] cursor
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              rx_ready_q, rx_ready_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdata;
  logic              accept;
  logic              newline;

`ifdef UART_TEXT_SCROLL_EN
  localparam logic [ADDR_W-1:0] SCR_LAST = ADDR_W'(COLS * (ROWS - 1) - 1);

  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        hold_q, hold_d;
  logic [ADDR_W-1:0] scr_raddr;
  logic [7:0]        scr_rdata;

  // The cell one row below the current destination index is the copy source.
  assign scr_raddr = idx_q + ADDR_W'(COLS);
`endif

  assign accept   = rx_valid && rx_ready_q;
  assign rx_ready = rx_ready_q;
  assign cursor   = {row_q, col_q};

  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    col_d      = col_q;
    row_d      = row_q;
    rx_ready_d = rx_ready_q;
    ram_we     = 1'b0;
    ram_waddr  = clr_q;
    ram_wdata  = BLANK_CHAR;
    newline    = 1'b0;
`ifdef UART_TEXT_SCROLL_EN
    idx_d      = idx_q;
    hold_d     = hold_q;
`endif

    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_q;
        if (clr_q == LAST_CELL) begin
          state_d    = ST_IDLE;
          rx_ready_d = 1'b1;
          clr_d      = '0;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end

      ST_IDLE: begin
        if (accept) begin
          if (rx_data >= PRINT_MIN && rx_data <= PRINT_MAX) begin
            ram_we    = 1'b1;
            ram_waddr = {row_q, col_q};
            ram_wdata = rx_data;
            if (col_q == LAST_COL) begin
              newline = 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            case (rx_data)
              CH_CR: col_d = '0;
              CH_LF: newline = 1'b1;
              CH_BS: begin
                if (col_q != '0) begin
                  col_d     = col_q - 1'b1;
                  ram_we    = 1'b1;
                  ram_waddr = {row_q, col_q - 1'b1};
                end
              end
              CH_FF: begin
                row_d      = '0;
                col_d      = '0;
                clr_d      = '0;
                state_d    = ST_CLEAR;
                rx_ready_d = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end

`ifdef UART_TEXT_SCROLL_EN
      ST_SCR_RD: begin
        hold_d  = scr_rdata;
        state_d = ST_SCR_WR;
      end

      ST_SCR_WR: begin
        ram_we    = 1'b1;
        ram_waddr = idx_q;
        ram_wdata = hold_q;
        idx_d     = idx_q + 1'b1;
        state_d   = (idx_q == SCR_LAST) ? ST_SCR_BLANK : ST_SCR_RD;
      end

      // Index continues straight into the last row, blanking it cell by cell.
      ST_SCR_BLANK: begin
        ram_we    = 1'b1;
        ram_waddr = idx_q;
        if (idx_q == LAST_CELL) begin
          state_d    = ST_IDLE;
          rx_ready_d = 1'b1;
          row_d      = LAST_ROW;
          col_d      = '0;
          idx_d      = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
`endif

      default: begin
        state_d    = ST_CLEAR;
        clr_d      = '0;
        rx_ready_d = 1'b0;
      end
    endcase

    if (newline) begin
      col_d = '0;
      if (row_q != LAST_ROW) begin
        row_d = row_q + 1'b1;
      end else begin
`ifdef UART_TEXT_SCROLL_EN
        state_d    = ST_SCR_RD;
        idx_d      = '0;
        rx_ready_d = 1'b0;
`else
        row_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      rx_ready_q <= 1'b0;
`ifdef UART_TEXT_SCROLL_EN
      idx_q      <= '0;
      hold_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      rx_ready_q <= rx_ready_d;
`ifdef UART_TEXT_SCROLL_EN
      idx_q      <= idx_d;
      hold_q     <= hold_d;
`endif
    end
  end

  char_ram #(
    .DEPTH (COLS * ROWS),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .rd_addr (charAddress),
    .rd_data (charOutput)
`ifdef UART_TEXT_SCROLL_EN
    ,
    .scr_addr(scr_raddr),
    .scr_data(scr_rdata)
`endif
  );

endmodule
